// File: rtl/rd_fwft_stage_if.sv
// ---------------------------------------------------------------------------
// rd_fwft_stage_if
// Groups the signals between the read-pointer stage, the FWFT output stage
// and the downstream consumer.
//   rempty  : registered FIFO empty flag (read-pointer stage -> stage)
//   rinc    : pop request (stage -> read-pointer stage)
//   rdata   : memory read data, valid the cycle after a pop
//   m_valid : output word available
//   m_ready : downstream accepts the word
//   m_data  : head-of-queue word
//   m_level : buffered word count, 0..2
// The slave modport is the stage's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface rd_fwft_stage_if #(
  parameter int DSIZE = 8
);
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic [1:0]       m_level;

  modport slave (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data, m_level
  );

  modport master (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, m_level
  );
endinterface

// File: rtl/rd_fwft_stage.sv
// ---------------------------------------------------------------------------
// rd_fwft_stage
// Turns a pop-request / latency-1 memory read interface into a
// first-word-fall-through valid/ready stream, using a 2-entry in-order
// buffer (head, tail) and a credit rule that never over-fills it.
// Ports:
//   rclk   : read-domain clock, all state changes on its rising edge
//   rrst_n : synchronous active-low reset
//   bus    : rd_fwft_stage_if.slave (rempty/rinc/rdata toward the FIFO,
//            m_valid/m_ready/m_data/m_level toward the consumer)
// ---------------------------------------------------------------------------
module rd_fwft_stage #(
  parameter int DSIZE = 8
) (
  input  logic           rclk,
  input  logic           rrst_n,
  rd_fwft_stage_if.slave bus
);

  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic             r_valid;

  logic             w_deq;
  logic [1:0]       w_occ_after_deq;
  logic [1:0]       w_occ_nxt;
  logic [2:0]       w_credit;
  logic             w_rinc;

  assign w_deq           = r_valid & bus.m_ready;
  assign w_occ_after_deq = r_occ - {1'b0, w_deq};
  assign w_occ_nxt       = w_occ_after_deq + {1'b0, r_inflight};

  // Words already held plus the one on its way, minus the one leaving now.
  // A deq implies r_occ >= 1, so this never wraps below zero.
  assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_rinc   = rrst_n & ~bus.rempty & (w_credit < 3'd2);

  // Pop request -> in-flight word -> buffer capture
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= w_rinc;
      r_valid    <= (w_occ_nxt != 2'd0);
      // Full buffer draining: tail advances to head.
      if (w_deq && (r_occ == 2'd2)) begin
        r_head <= r_tail;
      end
      // Arriving word lands in head only if nothing older remains after
      // this cycle's deq; otherwise it queues behind in tail.
      if (r_inflight) begin
        if (w_occ_after_deq == 2'd0) begin
          r_head <= bus.rdata;
        end else begin
          r_tail <= bus.rdata;
        end
      end
    end
  end

  assign bus.rinc    = w_rinc;
  assign bus.m_valid = r_valid;
  assign bus.m_data  = r_head;
  assign bus.m_level = r_occ;

endmodule
